// File: rtl/tx_mod_pkg.sv
// tx_mod_pkg: shared state encoding, default parameters and width helper for the BPSK modulator.
package tx_mod_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, DONE = 2'd3} state_e;
  localparam int DEF_CPP = 8;
  localparam int DEF_PPB = 5;
  localparam int DEF_SEQ_LEN = 1024;
  localparam int DEF_NUM_SEQ = 64;
  localparam int DEF_REPW = 8;
  function automatic int clog2_safe(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/tx_bit_timer.sv
// tx_bit_timer: clock/period/bit counters that pace the carrier and the sequence bits.
module tx_bit_timer
  import tx_mod_pkg::*;
#(
  parameter int CPP = DEF_CPP,
  parameter int PPB = DEF_PPB,
  parameter int SEQ_LEN = DEF_SEQ_LEN
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            clr_i,
  input  logic                            en_i,
  output logic                            half_o,
  output logic                            bit_end_o,
  output logic                            pass_end_o,
  output logic [clog2_safe(SEQ_LEN)-1:0]  bit_idx_o
);
  localparam int CW = clog2_safe(CPP);
  localparam int PW = clog2_safe(PPB);
  localparam int IW = clog2_safe(SEQ_LEN);
  logic [CW-1:0] clk_q, clk_d;
  logic [PW-1:0] per_q, per_d;
  logic [IW-1:0] idx_q, idx_d;
  logic clk_wrap, per_wrap;
  // half_o describes the cycle after the coming edge so the output register can be loaded ahead
  always_comb begin
    clk_wrap = clk_q == CW'(CPP - 1);
    per_wrap = per_q == PW'(PPB - 1);
    bit_end_o = en_i && clk_wrap && per_wrap;
    pass_end_o = bit_end_o && (idx_q == IW'(SEQ_LEN - 1));
    clk_d = clr_i ? '0 : !en_i ? clk_q : clk_wrap ? '0 : clk_q + 1'b1;
    per_d = clr_i ? '0 : !(en_i && clk_wrap) ? per_q : per_wrap ? '0 : per_q + 1'b1;
    idx_d = clr_i ? '0 : !bit_end_o ? idx_q : pass_end_o ? '0 : idx_q + 1'b1;
    half_o = clk_d >= CW'(CPP / 2);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_q <= '0;
      per_q <= '0;
      idx_q <= '0;
    end else begin
      clk_q <= clk_d;
      per_q <= per_d;
      idx_q <= idx_d;
    end
  end
  assign bit_idx_o = idx_q;
endmodule

// File: rtl/tx_bpsk_modulator.sv
// tx_bpsk_modulator: picks one sequence from the bank and sends it LSB-first as a BPSK square carrier,
// with repeat passes, abort and busy/done status.
module tx_bpsk_modulator
  import tx_mod_pkg::*;
#(
  parameter int CPP = DEF_CPP,
  parameter int PPB = DEF_PPB,
  parameter int SEQ_LEN = DEF_SEQ_LEN,
  parameter int NUM_SEQ = DEF_NUM_SEQ,
  parameter int SELW = clog2_safe(NUM_SEQ),
  parameter int REPW = DEF_REPW
) (
  input  logic                           ctx_clk,
  input  logic                           rtx_rst,
  input  logic                           ienable,
  input  logic                           istart,
  input  logic [SELW-1:0]                isel,
  input  logic [REPW-1:0]                irepeat,
  input  logic                           iabort,
  input  logic [NUM_SEQ*SEQ_LEN-1:0]     isequences,
  output logic                           omodulation,
  output logic                           obusy,
  output logic                           odone,
  output logic [clog2_safe(SEQ_LEN)-1:0] obit_idx
);
  state_e state_q, state_d;
  logic [SELW-1:0] sel_q, sel_d;
  logic [REPW-1:0] lim_q, lim_d, rep_q, rep_d;
  logic [SEQ_LEN-1:0] sr_q, sr_d, seq;
  logic mod_q, mod_d, kill, half, bit_end, pass_end;
  tx_bit_timer #(.CPP(CPP), .PPB(PPB), .SEQ_LEN(SEQ_LEN)) u_timer (
    .clk        (ctx_clk),
    .rst        (rtx_rst),
    .clr_i      (kill || state_q != RUN),
    .en_i       (state_q == RUN),
    .half_o     (half),
    .bit_end_o  (bit_end),
    .pass_end_o (pass_end),
    .bit_idx_o  (obit_idx)
  );
  // out-of-range selects match no entry and fall back to sequence 0
  always_comb begin
    seq = isequences[SEQ_LEN-1:0];
    for (int k = 1; k < NUM_SEQ; k++)
      if (sel_q == SELW'(k)) seq = isequences[k*SEQ_LEN +: SEQ_LEN];
  end
  always_comb begin
    kill = iabort || !ienable;
    state_d = state_q;
    sel_d = sel_q;
    lim_d = lim_q;
    rep_d = rep_q;
    sr_d = sr_q;
    case (state_q)
      IDLE: if (istart) begin
        state_d = LOAD;
        sel_d = isel;
        lim_d = irepeat;
      end
      LOAD: begin
        state_d = RUN;
        sr_d = seq;
        rep_d = '0;
      end
      RUN: if (pass_end && rep_q < lim_q) begin
        rep_d = rep_q + 1'b1;
        sr_d = seq;
      end else if (pass_end) state_d = DONE;
      else if (bit_end) sr_d = sr_q >> 1;
      default: state_d = IDLE;
    endcase
    if (kill) begin
      state_d = IDLE;
      rep_d = '0;
    end
    mod_d = (state_d == RUN) && (sr_d[0] ^ half);
  end
  always_ff @(posedge ctx_clk) begin
    if (rtx_rst) begin
      state_q <= IDLE;
      sel_q <= '0;
      lim_q <= '0;
      rep_q <= '0;
      sr_q <= '0;
      mod_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      lim_q <= lim_d;
      rep_q <= rep_d;
      sr_q <= sr_d;
      mod_q <= mod_d;
    end
  end
  assign omodulation = mod_q;
  assign obusy = (state_q == LOAD) || (state_q == RUN);
  assign odone = state_q == DONE;
endmodule

// File: tb/tb_tx_bpsk_modulator.sv
// tb_tx_bpsk_modulator: schedule-based reference model plus directed scenarios for the BPSK modulator.
module tb_tx_bpsk_modulator;
  typedef struct packed {logic mod; logic busy; logic done; logic [2:0] idx;} exp_t;
  typedef exp_t eq_t[$];
  logic clk = 1'b0, rst, en, st, ab;
  logic [1:0] sel;
  logic [7:0] rep;
  logic [31:0] bank;
  logic mod4, busy4, done4, mod3, busy3, done3;
  logic [2:0] idx4, idx3;
  int tests = 0, fails = 0;
  exp_t c4 = '0, c3 = '0;
  eq_t q4, q3;
  always #5 clk = ~clk;
  tx_bpsk_modulator #(.CPP(4), .PPB(2), .SEQ_LEN(8), .NUM_SEQ(4)) u_dut4 (
    .ctx_clk(clk), .rtx_rst(rst), .ienable(en), .istart(st), .isel(sel), .irepeat(rep),
    .iabort(ab), .isequences(bank), .omodulation(mod4), .obusy(busy4), .odone(done4), .obit_idx(idx4));
  tx_bpsk_modulator #(.CPP(4), .PPB(2), .SEQ_LEN(8), .NUM_SEQ(3)) u_dut3 (
    .ctx_clk(clk), .rtx_rst(rst), .ienable(en), .istart(st), .isel(sel), .irepeat(rep),
    .iabort(ab), .isequences(bank[23:0]), .omodulation(mod3), .obusy(busy3), .odone(done3), .obit_idx(idx3));
  // Whole transmission as seen from outside: one LOAD cycle, (rep+1) passes of bits, one DONE cycle.
  function automatic eq_t sched(input logic [7:0] s, input int r);
    eq_t q;
    q.push_back({1'b0, 1'b1, 1'b0, 3'd0});
    for (int p = 0; p <= r; p++)
      for (int b = 0; b < 8; b++)
        for (int c = 0; c < 8; c++)
          q.push_back({s[b] ^ ((c % 4) >= 2), 1'b1, 1'b0, 3'(b)});
    q.push_back({1'b0, 1'b0, 1'b1, 3'd0});
    return q;
  endfunction
  function automatic logic [7:0] pick(input int s, input int n);
    logic [31:0] b;
    b = bank;
    return (s >= n) ? b[7:0] : b[s*8 +: 8];
  endfunction
  always @(posedge clk) begin
    if (rst || ab || !en) begin
      q4.delete();
      q3.delete();
      c4 <= '0;
      c3 <= '0;
    end else if (q4.size() != 0) begin
      c4 <= q4.pop_front();
      c3 <= q3.pop_front();
    end else if (st && !c4.done) begin
      q4 = sched(pick(int'(sel), 4), int'(rep));
      q3 = sched(pick(int'(sel), 3), int'(rep));
      c4 <= q4.pop_front();
      c3 <= q3.pop_front();
    end else begin
      c4 <= '0;
      c3 <= '0;
    end
  end
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", n, $time, a, e);
    end
  endtask
  always @(negedge clk) begin
    chk("mod4", 32'(mod4), 32'(c4.mod));
    chk("busy4", 32'(busy4), 32'(c4.busy));
    chk("done4", 32'(done4), 32'(c4.done));
    chk("idx4", 32'(idx4), 32'(c4.idx));
    chk("mod3", 32'(mod3), 32'(c3.mod));
    chk("busy3", 32'(busy3), 32'(c3.busy));
    chk("done3", 32'(done3), 32'(c3.done));
    chk("idx3", 32'(idx3), 32'(c3.idx));
  end
  task automatic go(input logic [1:0] s, input logic [7:0] r);
    @(negedge clk);
    st = 1'b1;
    sel = s;
    rep = r;
    @(negedge clk);
    st = 1'b0;
    chk("load_busy", 32'(busy4), 32'd1);
    chk("load_mod", 32'(mod4), 32'd0);
  endtask
  task automatic scen2();
    logic [31:0] cap;
    go(2'd2, 8'd0);
    cap = '0;
    repeat (32) begin
      @(negedge clk);
      cap = {cap[30:0], mod4};
    end
    chk("wave_seq2", cap, 32'hCC33CC33);
    repeat (32) @(negedge clk);
    chk("t65_done", 32'(done4), 32'd0);
    chk("t65_busy", 32'(busy4), 32'd1);
    @(negedge clk);
    chk("t66_done", 32'(done4), 32'd1);
    chk("t66_busy", 32'(busy4), 32'd0);
    @(negedge clk);
    chk("t67_done", 32'(done4), 32'd0);
  endtask
  initial begin
    int run, dn;
    logic [15:0] cap4, cap3;
    rst = 1'b1; en = 1'b1; st = 1'b0; ab = 1'b0; sel = '0; rep = '0;
    bank = {8'hE1, 8'h05, 8'h3C, 8'hA7};
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    chk("idle_mod", 32'(mod4), 32'd0);
    scen2();
    go(2'd1, 8'd2);
    run = 0;
    dn = 0;
    repeat (200) begin
      @(negedge clk);
      run += int'(busy4);
      dn += int'(done4);
    end
    chk("rep2_run", 32'(run), 32'd192);
    chk("rep2_done", 32'(dn), 32'd1);
    go(2'd0, 8'd0);
    repeat (10) @(negedge clk);
    ab = 1'b1;
    @(negedge clk);
    ab = 1'b0;
    chk("abort_busy", 32'(busy4), 32'd0);
    chk("abort_mod", 32'(mod4), 32'd0);
    repeat (70) @(negedge clk);
    go(2'd0, 8'd0);
    repeat (10) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    en = 1'b1;
    chk("disable_busy", 32'(busy4), 32'd0);
    chk("disable_done", 32'(done4), 32'd0);
    repeat (70) @(negedge clk);
    go(2'd3, 8'd0);
    cap4 = '0;
    cap3 = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      cap4 = {cap4[14:0], mod4};
      cap3 = {cap3[14:0], mod3};
      st = (i == 4);
    end
    st = 1'b0;
    chk("wave_sel3", 32'(cap4), 32'h0000CC33);
    chk("wave_sel3_oor", 32'(cap3), 32'h0000CCCC);
    repeat (49) @(negedge clk);
    chk("ign_done", 32'(done4), 32'd1);
    st = 1'b1;
    @(negedge clk);
    st = 1'b0;
    chk("ign_start_in_done", 32'(busy4), 32'd0);
    repeat (3) @(negedge clk);
    go(2'd1, 8'd0);
    repeat (20) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_outs", {28'(0), mod4, busy4, done4, |idx4}, 32'd0);
    scen2();
    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/tx_bpsk_modulator.md
# tx_bpsk_modulator

Parametrised BPSK square-wave modulator for the transmit chain. It selects one pseudo-random binary sequence from a bank of `NUM_SEQ` sequences and emits it LSB-first as a BPSK-modulated square carrier. Carrier period, periods per bit and sequence length are parameters. It adds a repeat count, abort, and busy/done status on top of the fixed single-sequence modulator. It sits between the sequence generator bank and the transducer driver.

## Interface
- `CPP`, 8, clocks per carrier period; even, ≥2
- `PPB`, 5, carrier periods per bit; ≥1
- `SEQ_LEN`, 1024, bits per sequence; ≥2
- `NUM_SEQ`, 64, number of sequences in the bank; ≥1
- `SELW`, max(1,$clog2(NUM_SEQ)), derived width of `isel`
- `REPW`, 8, width of the repeat count
- `ctx_clk`  in  1  clock; the block uses this single clock only
- `rtx_rst`  in  1  reset; synchronous, active-high
- `ienable`  in  1  enable; low forces IDLE
- `istart`  in  1  start request; sampled only in IDLE
- `isel`  in  SELW  sequence index; sampled with `istart`
- `irepeat`  in  REPW  extra passes after the first; sampled with `istart`
- `iabort`  in  1  abort the current transmission
- `isequences`  in  NUM_SEQ*SEQ_LEN  sequence bank; sequence k occupies bits [k*SEQ_LEN +: SEQ_LEN]
- `omodulation`  out  1  modulated output (registered)
- `obusy`  out  1  high in LOAD and RUN
- `odone`  out  1  one-cycle pulse on normal completion
- `obit_idx`  out  $clog2(SEQ_LEN)  index of the bit being transmitted

## Operation
- States are IDLE, LOAD, RUN and DONE.
- IDLE:
  - If `istart` && `ienable`, latch `isel` and `irepeat`, then go to LOAD.
  - If `isel` ≥ NUM_SEQ, use sequence 0.
- LOAD (1 cycle): copy the selected sequence into the shift register, clear all counters, go to RUN.
- RUN: three nested counters.
  - `clk_cnt` counts 0..CPP-1.
  - `per_cnt` counts 0..PPB-1; it advances when `clk_cnt` wraps.
  - `bit_idx` counts 0..SEQ_LEN-1; it advances when both `clk_cnt` and `per_cnt` wrap.
- Current bit = shift register [0]; the register shifts right by 1 at each bit end.
- Output in RUN: `omodulation` = bit XOR (`clk_cnt` ≥ CPP/2). A bit of 1 is therefore high for the first half-period and low for the second.
- Pass end (`bit_idx`=SEQ_LEN-1, last clock of last period):
  - If `rep_cnt` < latched `irepeat`: increment `rep_cnt`, reload the sequence from the latched `isel`, stay in RUN with no gap.
  - Otherwise go to DONE.
- DONE (1 cycle): `odone`=1, then go to IDLE. `istart` is ignored in DONE.
- `iabort` or !`ienable` in any state: go to IDLE at the next edge, clear counters, `omodulation`=0, no `odone`. Abort has priority over pass-end and repeat.
- `istart` outside IDLE is ignored.
- `isequences` changes during RUN have no effect except at a repeat reload, where the bank is re-read.

## Timing
- Reset values: state IDLE; `omodulation`=0, `obusy`=0, `odone`=0, `obit_idx`=0; all counters and the shift register are 0.
- `omodulation` is 0 in IDLE, LOAD and DONE.
- `istart` sampled at edge t:
  - LOAD during cycle t+1 (`obusy`=1).
  - RUN from t+2; `omodulation` during cycle t+2 carries bit 0, first half.
- One pass lasts SEQ_LEN·PPB·CPP cycles. Total RUN lasts (irepeat+1)·SEQ_LEN·PPB·CPP cycles.
- `odone` is high in the cycle after the last RUN cycle. `obusy` falls in that same cycle.
- Earliest next start: `istart` seen in the cycle after DONE.
- Reset asserted mid-RUN: all outputs are at reset values in the following cycle.
- `obit_idx` is registered and changes on the same edge as the shift.

## Structure
- Package `tx_mod_pkg` holds:
  - the state enum (IDLE=0, LOAD=1, RUN=2, DONE=3);
  - the default parameter constants;
  - the helper function for safe `$clog2` of 1.
- Sub-module `tx_bit_timer` holds the `clk_cnt`/`per_cnt`/`bit_idx` counters. It provides `half` (`clk_cnt` ≥ CPP/2), `bit_end` and `pass_end` strobes, plus a synchronous clear input.
- The top level holds the FSM, the bank mux, the shift register, the repeat counter and the output register.

## Test plan
All scenarios use CPP=4, PPB=2, SEQ_LEN=8, NUM_SEQ=4.
- Reset, then idle 20 cycles → `omodulation`=0, `obusy`=0, `odone`=0 throughout.
- Seq 2 = 8'b0000_0101, `isel`=2, `irepeat`=0, start at t:
  - LOAD at t+1.
  - From t+2, output is 1100 1100 0011 0011 1100 1100 0011 0011 …, then 0011 0011 for bits 3..7.
  - `odone` at t+66, `obusy` low at t+66.
- `irepeat`=2 → 192 contiguous RUN cycles; sequence restarts at bit 0 with no gap; exactly one `odone`.
- `iabort` at RUN cycle 10 → IDLE next cycle, `omodulation`=0, no `odone`. The same check applies with `ienable` dropped.
- `istart` pulsed during RUN and during DONE → ignored, pass length unchanged. `isel`=3 with NUM_SEQ=3 → sequence 0 transmitted.
- `rtx_rst` asserted mid-RUN → every output at its reset value in the next cycle. A new start then behaves as in scenario 2.
